// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the obstacle scheduler: state encoding,
// obstacle indices and their one-hot select codes.
package obstacle_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PICK     = 3'd1,
        ST_START    = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_RUN      = 3'd4,
        ST_GAP      = 3'd5,
        ST_FINISH   = 3'd6
    } state_e;

    localparam logic [1:0] OBS_VLASER = 2'd0;
    localparam logic [1:0] OBS_HLASER = 2'd1;
    localparam logic [1:0] OBS_RSVD2  = 2'd2;
    localparam logic [1:0] OBS_RSVD3  = 2'd3;

    localparam logic [3:0] SEL_NONE   = 4'b0000;
    localparam logic [3:0] SEL_VLASER = 4'b0001;
    localparam logic [3:0] SEL_HLASER = 4'b0010;
    localparam logic [3:0] SEL_RSVD2  = 4'b0100;
    localparam logic [3:0] SEL_RSVD3  = 4'b1000;

    localparam int CNT_W = 25;

    function automatic logic [3:0] sel_code(input logic [1:0] idx);
        logic [3:0] code;
        code = SEL_NONE;
        unique case (idx)
            OBS_VLASER: code = SEL_VLASER;
            OBS_HLASER: code = SEL_HLASER;
            OBS_RSVD2:  code = SEL_RSVD2;
            OBS_RSVD3:  code = SEL_RSVD3;
            default:    code = SEL_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/obstacle_scheduler_lfsr.sv
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1.
module obstacle_lfsr #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] rnd
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[6:0],
                  lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd = lfsr_q[1:0];

endmodule

// File: rtl/obstacle_scheduler.sv
// Sequences randomly chosen obstacles through a game of ROUNDS rounds,
// with an ACK timeout and an idle gap between obstacles.
module obstacle_scheduler
    import obstacle_scheduler_pkg::*;
#(
    parameter int unsigned GAP_CYCLES  = 32000000,
    parameter int unsigned ROUNDS      = 8,
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       game_on,
    input  logic       menu_on,
    input  logic       play_selected,
    input  logic [3:0] obs_working,
    input  logic [3:0] obs_done,
    output logic [3:0] selected,
    output logic       done_control,
    output logic [5:0] round_cnt,
    output logic       game_won,
    output logic       fault
);

    localparam logic [CNT_W-1:0] GAP_LAST = 25'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ACK_LAST = 25'(ACK_TIMEOUT - 1);
    localparam logic [5:0]       ROUNDS_C = 6'(ROUNDS);
    localparam logic [5:0]       RND_MAX  = 6'd63;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       round_q, round_d;
    logic [3:0]       sel_q, sel_d;
    logic             dc_q, dc_d;
    logic             won_q, won_d;
    logic             fault_q, fault_d;
    logic [1:0]       rnd;
    logic [1:0]       pick_idx;
    logic             abort;

    obstacle_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk(pclk),
        .rst(rst),
        .rnd(rnd)
    );

    assign abort = menu_on || !play_selected;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        round_d = round_q;
        fault_d = fault_q;

        // Never pick the same obstacle twice in a row within a game.
        pick_idx = rnd;
        if (pick_idx == idx_q && round_q != 6'd0) begin
            pick_idx = pick_idx + 2'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (game_on && play_selected && !menu_on) begin
                    state_d = ST_PICK;
                end
            end
            ST_PICK: begin
                idx_d   = pick_idx;
                state_d = ST_START;
            end
            ST_START: begin
                cnt_d   = '0;
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (obs_working[idx_q]) begin
                    state_d = ST_RUN;
                end else if (cnt_q == ACK_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (obs_done[idx_q]) begin
                    round_d = (round_q == RND_MAX) ? round_q
                                                   : round_q + 6'd1;
                    cnt_d   = '0;
                    state_d = (round_d == ROUNDS_C) ? ST_FINISH : ST_GAP;
                end else if (!obs_working[idx_q]) begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = ST_PICK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FINISH: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Leaving the game screen overrides everything in an active game.
        if (abort && state_q != ST_IDLE && state_q != ST_FINISH) begin
            state_d = ST_IDLE;
            idx_d   = idx_q;
            round_d = round_q;
            fault_d = fault_q;
        end

        if (state_d == ST_IDLE && state_q != ST_IDLE) begin
            round_d = '0;
        end

        // Outputs are registered copies of what the next state presents.
        sel_d = SEL_NONE;
        if (state_d inside {ST_START, ST_WAIT_ACK, ST_RUN}) begin
            sel_d = sel_code(idx_d);
        end
        dc_d  = (state_d == ST_START);
        won_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= OBS_VLASER;
            cnt_q   <= '0;
            round_q <= '0;
            sel_q   <= SEL_NONE;
            dc_q    <= 1'b0;
            won_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            round_q <= round_d;
            sel_q   <= sel_d;
            dc_q    <= dc_d;
            won_q   <= won_d;
            fault_q <= fault_d;
        end
    end

    assign selected     = sel_q;
    assign done_control = dc_q;
    assign round_cnt    = round_q;
    assign game_won     = won_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Directed bench for obstacle_scheduler with small gap/round/timeout values.
module tb_obstacle_scheduler;

    localparam int GAP = 10;
    localparam int RND = 2;
    localparam int ACK = 16;
    localparam logic [7:0] SEED = 8'hA5;

    logic       pclk;
    logic       rst;
    logic       game_on;
    logic       menu_on;
    logic       play_selected;
    logic [3:0] obs_working;
    logic [3:0] obs_done;
    logic [3:0] selected;
    logic       done_control;
    logic [5:0] round_cnt;
    logic       game_won;
    logic       fault;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    logic       dc_prev = 1'b0;
    logic [7:0] lfsr_m;

    obstacle_scheduler #(
        .GAP_CYCLES(GAP),
        .ROUNDS(RND),
        .ACK_TIMEOUT(ACK),
        .LFSR_SEED(SEED)
    ) dut (
        .pclk(pclk),
        .rst(rst),
        .game_on(game_on),
        .menu_on(menu_on),
        .play_selected(play_selected),
        .obs_working(obs_working),
        .obs_done(obs_done),
        .selected(selected),
        .done_control(done_control),
        .round_cnt(round_cnt),
        .game_won(game_won),
        .fault(fault)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic logic [7:0] lfsr_adv(input logic [7:0] v,
                                            input int n);
        logic [7:0] r;
        r = v;
        for (int i = 0; i < n; i++) r = lfsr_next(r);
        return r;
    endfunction

    function automatic int sel2idx(input logic [3:0] s);
        int r;
        r = 0;
        if (s[1]) r = 1;
        if (s[2]) r = 2;
        if (s[3]) r = 3;
        return r;
    endfunction

    // Reference LFSR, advanced on every clock outside reset.
    always @(posedge pclk or posedge rst) begin
        if (rst) lfsr_m <= SEED;
        else     lfsr_m <= lfsr_next(lfsr_m);
    end

    always @(negedge pclk) begin
        if (!rst) begin
            checks++;
            if (done_control && dc_prev) begin
                failures++;
                $display("FAIL dc_width got two-cycle strobe at t=%0t", $time);
            end
            checks++;
            if (!$onehot0(selected)) begin
                failures++;
                $display("FAIL sel_onehot got=%b exp=onehot-or-zero", selected);
            end
        end
        dc_prev = done_control;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge pclk);
        #1;
        cyc++;
    endtask

    task automatic wait_dc(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            tick();
            if (done_control) seen = 1'b1;
        end
    endtask

    task automatic serve_round(input int idx);
        repeat (3) tick();
        obs_working[idx] = 1'b1;
        repeat (20) tick();
        obs_done[idx] = 1'b1;
        tick();
        obs_done    = 4'b0;
        obs_working = 4'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        game_on = 1'b0;
        menu_on = 1'b0;
        play_selected = 1'b0;
        obs_working = 4'b0;
        obs_done = 4'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if (selected !== 4'b0) begin
            failures++;
            $display("FAIL rst_sel got=%b exp=0000", selected);
        end
        checks++;
        if (done_control !== 1'b0) begin
            failures++;
            $display("FAIL rst_dc got=%b exp=0", done_control);
        end
        checks++;
        if (round_cnt !== 6'd0) begin
            failures++;
            $display("FAIL rst_round got=%0d exp=0", round_cnt);
        end
        checks++;
        if ({game_won, fault} !== 2'b00) begin
            failures++;
            $display("FAIL rst_won_fault got=%b exp=00", {game_won, fault});
        end
    endtask

    task automatic test_full_game();
        bit seen;
        int t1;
        logic [3:0] s1;
        game_on = 1'b1;
        play_selected = 1'b1;
        wait_dc(4, seen);
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL game_start1 got=no_strobe exp=strobe");
        end
        t1 = cyc;
        s1 = selected;
        checks++;
        if (!$onehot(s1)) begin
            failures++;
            $display("FAIL game_sel1 got=%b exp=onehot", s1);
        end
        serve_round(sel2idx(s1));
        checks++;
        if (round_cnt !== 6'd1 || selected !== 4'b0) begin
            failures++;
            $display("FAIL game_round1 got=%0d/%b exp=1/0000",
                     round_cnt, selected);
        end
        wait_dc(20, seen);
        // 3 ack + 20 run + 1 done edge + GAP + 1 pick cycle
        checks++;
        if (!seen || (cyc - t1) != 35) begin
            failures++;
            $display("FAIL game_spacing got=%0d exp=35", cyc - t1);
        end
        checks++;
        if (selected === s1 || !$onehot(selected)) begin
            failures++;
            $display("FAIL game_sel2 got=%b exp=onehot!=%b", selected, s1);
        end
        serve_round(sel2idx(selected));
        checks++;
        if ({round_cnt, game_won, selected, done_control} !==
            {6'd2, 1'b1, 4'b0, 1'b0}) begin
            failures++;
            $display("FAIL game_won got=%0d/%b/%b exp=2/1/0000",
                     round_cnt, game_won, selected);
        end
        tick();
        checks++;
        if (game_won !== 1'b1) begin
            failures++;
            $display("FAIL won_hold got=%b exp=1", game_won);
        end
        play_selected = 1'b0;
        tick();
        checks++;
        if (game_won !== 1'b0 || round_cnt !== 6'd0) begin
            failures++;
            $display("FAIL won_exit got=%b/%0d exp=0/0", game_won, round_cnt);
        end
    endtask

    task automatic test_repeat_idx();
        bit seen;
        bit ok;
        logic [7:0] v;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            v = lfsr_next(lfsr_m);
            if (v[1:0] == 2'd1) ok = 1'b1;
            else tick();
        end
        play_selected = 1'b1;
        wait_dc(4, seen);
        checks++;
        if (!ok || !seen || selected !== 4'b0010) begin
            failures++;
            $display("FAIL rep_first got=%b exp=0010", selected);
        end
        repeat (3) tick();
        obs_working[1] = 1'b1;
        repeat (2) tick();
        ok = 1'b0;
        // done edge, GAP cycles, then the PICK cycle samples the LFSR
        for (int i = 0; i < 300 && !ok; i++) begin
            v = lfsr_adv(lfsr_m, GAP + 1);
            if (v[1:0] == 2'd1) ok = 1'b1;
            else tick();
        end
        obs_done[1] = 1'b1;
        tick();
        obs_done = 4'b0;
        obs_working = 4'b0;
        wait_dc(20, seen);
        checks++;
        if (!ok || !seen || selected !== 4'b0100) begin
            failures++;
            $display("FAIL rep_second got=%b exp=0100", selected);
        end
        play_selected = 1'b0;
        tick();
        checks++;
        if (selected !== 4'b0 || round_cnt !== 6'd0) begin
            failures++;
            $display("FAIL rep_abort got=%b/%0d exp=0000/0",
                     selected, round_cnt);
        end
    endtask

    task automatic test_menu_abort();
        bit seen;
        int idx;
        play_selected = 1'b1;
        wait_dc(4, seen);
        serve_round(sel2idx(selected));
        wait_dc(20, seen);
        idx = sel2idx(selected);
        repeat (3) tick();
        obs_working[idx] = 1'b1;
        repeat (5) tick();
        checks++;
        if (!seen || round_cnt !== 6'd1) begin
            failures++;
            $display("FAIL menu_pre got=%0d exp=1", round_cnt);
        end
        menu_on = 1'b1;
        obs_done[idx] = 1'b1;
        tick();
        obs_done = 4'b0;
        obs_working = 4'b0;
        checks++;
        if ({selected, round_cnt, game_won, done_control} !== 12'd0) begin
            failures++;
            $display("FAIL menu_abort got=%b/%0d/%b exp=0000/0/0",
                     selected, round_cnt, game_won);
        end
        play_selected = 1'b0;
        menu_on = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        bit seen;
        play_selected = 1'b1;
        wait_dc(4, seen);
        // START cycle plus ACK cycles in WAIT_ACK
        repeat (ACK) tick();
        checks++;
        if (!seen || fault !== 1'b0) begin
            failures++;
            $display("FAIL tmo_early got=%b exp=0", fault);
        end
        tick();
        checks++;
        if (fault !== 1'b1 || selected !== 4'b0 || done_control !== 1'b0) begin
            failures++;
            $display("FAIL tmo_fault got=%b/%b exp=1/0000", fault, selected);
        end
        play_selected = 1'b0;
        repeat (3) tick();
        checks++;
        if (fault !== 1'b1 || selected !== 4'b0) begin
            failures++;
            $display("FAIL tmo_sticky got=%b/%b exp=1/0000", fault, selected);
        end
    endtask

    task automatic test_reset_mid_run();
        bit seen;
        int idx;
        bit any_dc;
        logic [3:0] s;
        play_selected = 1'b1;
        wait_dc(4, seen);
        s = selected;
        idx = sel2idx(s);
        repeat (3) tick();
        obs_working[idx] = 1'b1;
        repeat (5) tick();
        checks++;
        if (!seen || selected !== s) begin
            failures++;
            $display("FAIL run_sel got=%b exp=%b", selected, s);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (selected !== 4'b0 || fault !== 1'b0) begin
            failures++;
            $display("FAIL run_rst_async got=%b/%b exp=0000/0",
                     selected, fault);
        end
        obs_working = 4'b0;
        play_selected = 1'b0;
        tick();
        rst = 1'b0;
        any_dc = 1'b0;
        repeat (5) begin
            tick();
            if (done_control) any_dc = 1'b1;
        end
        checks++;
        if (any_dc !== 1'b0) begin
            failures++;
            $display("FAIL run_rst_dc got=%b exp=0", any_dc);
        end
    endtask

    task automatic test_reset_mid_gap();
        bit seen;
        play_selected = 1'b1;
        wait_dc(4, seen);
        serve_round(sel2idx(selected));
        repeat (3) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (!seen || {selected, done_control, round_cnt, game_won, fault}
            !== 13'd0) begin
            failures++;
            $display("FAIL gap_rst got=%b/%b/%0d/%b/%b exp=all0",
                     selected, done_control, round_cnt, game_won, fault);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (done_control !== 1'b0) begin
            failures++;
            $display("FAIL gap_pick got=%b exp=0", done_control);
        end
        tick();
        checks++;
        if (done_control !== 1'b1 || !$onehot(selected)) begin
            failures++;
            $display("FAIL gap_restart got=%b/%b exp=1/onehot",
                     done_control, selected);
        end
        play_selected = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_full_game();
        test_repeat_idx();
        test_menu_abort();
        test_timeout();
        test_reset_mid_run();
        test_reset_mid_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/obstacle_scheduler.md
OBSTACLE_SCHEDULER -- requirements
Module: obstacle_scheduler

Interface
REQ-001 Parameter GAP_CYCLES, default 32000000: idle pause between two obstacles, in pclk cycles.
REQ-002 Parameter ROUNDS, default 8: number of obstacles per game.
REQ-003 Parameter ACK_TIMEOUT, default 1024: cycles allowed for a started obstacle to raise working.
REQ-004 Parameter LFSR_SEED, default 8'hA5: nonzero LFSR reset value.
REQ-005 pclk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 game_on  input  1  game screen active.
REQ-008 menu_on  input  1  menu screen active; aborts scheduling.
REQ-009 play_selected  input  1  play chosen; low aborts scheduling.
REQ-010 obs_working  input  4  per-obstacle working flags, bit i = obstacle i.
REQ-011 obs_done  input  4  per-obstacle one-cycle done pulses.
REQ-012 selected  output  4  one-hot code of the obstacle to run; 4'b0000 when none.
REQ-013 done_control  output  1  one-cycle start strobe, valid with selected.
REQ-014 round_cnt  output  6  obstacles completed in current game.
REQ-015 game_won  output  1  level, high after ROUNDS obstacles completed.
REQ-016 fault  output  1  sticky, high after an ACK timeout.

Function
REQ-017 All outputs and internal state SHALL be registered; next-state logic is combinational.
REQ-018 States: IDLE, PICK, START, WAIT_ACK, RUN, GAP, FINISH.
REQ-019 IDLE: outputs selected=0, done_control=0; leave to PICK when game_on && play_selected && !menu_on; round_cnt cleared on entry from FINISH or abort.
REQ-020 PICK (1 cycle): idx = lfsr[1:0]; if idx equals previous idx and round_cnt!=0, idx = idx+1 mod 4; selected <= 1<<idx; go START.
REQ-021 START (1 cycle): done_control=1, selected held; go WAIT_ACK with timeout counter cleared.
REQ-022 WAIT_ACK: obs_working[idx]=1 -> RUN; counter reaching ACK_TIMEOUT-1 -> fault<=1, IDLE.
REQ-023 RUN: obs_done[idx]=1 -> round_cnt+1, then FINISH if new count == ROUNDS, else GAP; obs_done on other bits ignored.
REQ-024 RUN: obs_working[idx] falling without obs_done[idx] -> IDLE (obstacle self-aborted).
REQ-025 GAP: selected=0; counter counts 0..GAP_CYCLES-1, then PICK.
REQ-026 FINISH: game_won=1, selected=0; stays until menu_on or !play_selected, then IDLE with game_won<=0.
REQ-027 From any non-IDLE, non-FINISH state, menu_on=1 or play_selected=0 SHALL force IDLE next cycle; takes priority over every other transition including a simultaneous obs_done.
REQ-028 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every cycle regardless of state.
REQ-029 Gap and timeout counters 25 bits; round_cnt saturates at 63; no wrap.
REQ-030 done_control SHALL never be high for two consecutive cycles.

Reset
REQ-031 On rst: state=IDLE, selected=0, done_control=0, round_cnt=0, game_won=0, fault=0, counters=0, lfsr=LFSR_SEED, previous idx=0.
REQ-032 Reset asserted mid-RUN SHALL drop selected to 0 asynchronously, with no done_control pulse after release until a new PICK.

Structure
REQ-033 Shared package SHALL hold state encoding (3 bits), obstacle index constants (0 vertical lasers, 1 horizontal lasers, 2 and 3 reserved obstacles), and the one-hot select codes.
REQ-034 One sub-module: obstacle_lfsr (8-bit, parameterised seed, enable-free).

Verification
REQ-035 GAP_CYCLES=10, ROUNDS=2; play; model working 3 cycles after done_control, done 20 cycles later -> two START strobes ~30 cycles apart, round_cnt 1 then 2, game_won=1, selected=0.
REQ-036 Seed forcing idx 1 twice in a row -> second selected is 4'b0100, not 4'b0010.
REQ-037 No working response, ACK_TIMEOUT=16 -> fault=1 exactly 16 cycles after START, state IDLE, selected=0.
REQ-038 menu_on raised in RUN in the same cycle as obs_done[idx] -> IDLE next cycle, round_cnt not incremented and cleared.
REQ-039 rst pulsed mid-GAP -> all outputs 0 immediately; after release, START strobe only after new PICK.
REQ-040 Assertion over whole run: done_control one cycle wide and selected always one-hot or zero.
